// File: rtl/mem_pkg.sv
// Shared types and constants for the memory slave.
//   state_t       : controller FSM state encoding
//   ADDR_W_DEF    : default address width (depth = 2**ADDR_W)
//   DATA_W_DEF    : default data width
//   CNT_W         : wait-state counter width (wait states 0..15)
package mem_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2,
    LOAD  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port storage, synchronous write and combinational read, no reset.
//   clk     : write clock
//   we      : write enable
//   addr    : shared read/write address
//   wdata   : write data
//   rdata_c : combinational read data at addr
module mem_array #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_c
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata_c = mem[addr];

endmodule

// File: rtl/mem_ctrl.sv
// Memory slave for the CPU bus: req/ready four-phase handshake with
// programmable wait states, plus a side load port for the program image.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req, we, addr, wdata: CPU request (latched on accept)
//   rdata, ready        : CPU response (registered)
//   ld_en, ld_addr,
//   ld_data             : load-port write request (hold until ld_ack)
//   ld_ack              : one-cycle pulse while the load write is in flight
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ack
);

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;

  logic [ADDR_W-1:0] addr_l, ld_addr_l;
  logic [DATA_W-1:0] wdata_l, ld_data_l;
  logic              we_l;

  logic              accept, ld_start, commit;
  logic              ready_d, ld_ack_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  // State and wait counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next-state and control strobes.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    accept   = 1'b0;
    ld_start = 1'b0;
    commit   = 1'b0;
    ready_d  = 1'b0;
    ld_ack_d = 1'b0;
    case (state)
      IDLE: begin
        // Load port wins a tie with the CPU.
        if (ld_en) begin
          ld_start = 1'b1;
          ld_ack_d = 1'b1;
          state_d  = LOAD;
        end else if (req) begin
          accept  = 1'b1;
          cnt_d   = CNT_W'(WAIT_STATES);
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A dropped request aborts before anything is committed.
        if (!req) begin
          state_d = IDLE;
        end else if (cnt == '0) begin
          commit  = 1'b1;
          state_d = READY;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      READY: begin
        // ready rises one edge after entry so rdata is settled first.
        if (!req) state_d = IDLE;
        else      ready_d = 1'b1;
      end
      LOAD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request and load-port latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_l    <= '0;
      we_l      <= 1'b0;
      wdata_l   <= '0;
      ld_addr_l <= '0;
      ld_data_l <= '0;
    end else begin
      if (accept) begin
        addr_l  <= addr;
        we_l    <= we;
        wdata_l <= wdata;
      end
      if (ld_start) begin
        ld_addr_l <= ld_addr;
        ld_data_l <= ld_data;
      end
    end
  end

  // Registered outputs; rdata only moves on commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      ready  <= 1'b0;
      ld_ack <= 1'b0;
    end else begin
      ready  <= ready_d;
      ld_ack <= ld_ack_d;
      if (commit) rdata <= we_l ? wdata_l : mem_rdata;
    end
  end

  // Array write-port mux: load cycle vs CPU commit.
  always_comb begin
    mem_we    = (commit && we_l) || (state == LOAD);
    mem_addr  = (state == LOAD) ? ld_addr_l : addr_l;
    mem_wdata = (state == LOAD) ? ld_data_l : wdata_l;
  end

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .we      (mem_we),
    .addr    (mem_addr),
    .wdata   (mem_wdata),
    .rdata_c (mem_rdata)
  );

endmodule
